// File: rtl/gemm_stream_host.sv
// gemm_stream_host: host-side packer/collector for a fixed-latency N x N GEMM kernel.
// Packs an input element stream (A then B, row-major) into flattened operand words.
// Holds the operands while the kernel latency elapses, then captures the flattened result.
// Replays the result as an element stream with a last flag.
// Optional feature macro: GEMM_HOST_JOBCNT_EN adds a 16-bit completed-job counter port job_cnt.
module gemm_stream_host #(
  parameter int DW       = 32,
  parameter int N        = 2,
  parameter int PIPE_LAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic [N*N*DW-1:0] arg0,
  output logic [N*N*DW-1:0] arg1,
  input  logic [N*N*DW-1:0] kern_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  output logic              busy
`ifdef GEMM_HOST_JOBCNT_EN
  ,
  output logic [15:0]       job_cnt
`endif
);

  localparam int NE    = N * N;
  localparam int IDXW  = ($clog2(2 * NE) > 0) ? $clog2(2 * NE) : 1;
  localparam int OIDXW = ($clog2(NE) > 0) ? $clog2(NE) : 1;
  localparam int WCW   = ($clog2(PIPE_LAT + 1) > 0) ? $clog2(PIPE_LAT + 1) : 1;

  localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(2 * NE - 1);
  localparam logic [IDXW-1:0]  IDX_BSTRT = IDXW'(NE);
  localparam logic [OIDXW-1:0] OIDX_LAST = OIDXW'(NE - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDXW-1:0]     idx_q;
  logic [OIDXW-1:0]    oidx_q;
  logic [WCW-1:0]      wcnt_q;
  logic [NE*DW-1:0]    arg0_q;
  logic [NE*DW-1:0]    arg1_q;
  logic [NE*DW-1:0]    res_q;

  // Main sequencer: load operands, wait out the kernel latency, then drain the captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      oidx_q  <= '0;
      wcnt_q  <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            if (idx_q < IDX_BSTRT) begin
              arg0_q[int'(idx_q)*DW +: DW] <= s_data;
            end else begin
              arg1_q[int'(idx_q - IDX_BSTRT)*DW +: DW] <= s_data;
            end
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              wcnt_q  <= WCW'(PIPE_LAT);
              state_q <= ST_WAIT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_q == '0) begin
            res_q   <= kern_out;
            state_q <= ST_DRAIN;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (oidx_q == OIDX_LAST) begin
              oidx_q  <= '0;
              state_q <= ST_LOAD;
            end else begin
              oidx_q <= oidx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

`ifdef GEMM_HOST_JOBCNT_EN
  logic [15:0] jobCnt_q;

  // Count completed jobs, one per final result transfer; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jobCnt_q <= '0;
    end else if ((state_q == ST_DRAIN) && m_ready && (oidx_q == OIDX_LAST)) begin
      jobCnt_q <= jobCnt_q + 16'd1;
    end
  end

  assign job_cnt = jobCnt_q;
`endif

  // Stream-side flags and result element are decoded from the registered state and indices.
  always_comb begin
    s_ready = (state_q == ST_LOAD);
    busy    = (state_q != ST_LOAD);
    m_valid = (state_q == ST_DRAIN);
    m_last  = (state_q == ST_DRAIN) && (oidx_q == OIDX_LAST);
    m_data  = '0;
    if (state_q == ST_DRAIN) begin
      m_data = res_q[int'(oidx_q)*DW +: DW];
    end
  end

  assign arg0 = arg0_q;
  assign arg1 = arg1_q;

endmodule

// File: doc/gemm_stream_host.md
Name: gemm_stream_host

Overview:
- Host-side driver and collector for the pipelined N×N GEMM kernel, which has flattened A/B operand inputs, a flattened C output and a fixed latency.
- Accepts a valid/ready element stream (all A elements, then all B elements, row-major) and packs it into the two flattened operand words.
- Holds the operands stable while the kernel latency elapses, then captures the flattened result.
- Replays the result as a valid/ready element stream with a last flag.
- Sits between the system stream fabric and the kernel; it is the other end of the kernel's packed-matrix interface.

Parameters:
- DW, 32, element width in bits.
- N, 2, matrix dimension; packed word width is N*N*DW.
- PIPE_LAT, 6, kernel register stages from operand capture to a valid result (kernel stages p0..p5).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- s_valid  in  1  input element valid.
- s_ready  out  1  block accepts an input element.
- s_data  in  DW  input element.
- arg0  out  N*N*DW  packed A to kernel; element k=i*N+j at bits [k*DW +: DW].
- arg1  out  N*N*DW  packed B to kernel; same packing as arg0.
- kern_out  in  N*N*DW  packed C from kernel; same packing.
- m_valid  out  1  result element valid.
- m_ready  in  1  downstream accepts a result element.
- m_data  out  DW  result element.
- m_last  out  1  high with the final result element (k=N*N-1).
- busy  out  1  high whenever the state is not LOAD.

Behaviour:
- Reset (rst low, asynchronous) values:
  - state=LOAD; all counters 0; arg0=arg1=0; result register 0.
  - m_valid=0, m_data=0, m_last=0, busy=0.
  - s_ready=1, since it is decoded from state.
- Handshakes:
  - An input transfer occurs when s_valid&&s_ready at a clock edge.
  - An output transfer occurs when m_valid&&m_ready at a clock edge.
  - Valids are never withdrawn by this block once asserted.
- FSM LOAD:
  - s_ready=1.
  - The element counter idx (0..2*N*N-1) selects the destination: idx<N*N writes the arg0 slot idx; otherwise it writes the arg1 slot idx-N*N.
  - On the transfer with idx=2*N*N-1: idx←0, wcnt←PIPE_LAT, go to WAIT.
- FSM WAIT:
  - s_ready=0.
  - wcnt decrements each edge.
  - At the edge where wcnt==0: result←kern_out, go to DRAIN.
  - Net effect: m_valid first rises PIPE_LAT+1 edges after the last input transfer.
- FSM DRAIN:
  - m_valid=1; m_data=result slot oidx; m_last=(oidx==N*N-1).
  - oidx advances on each output transfer.
  - On the transfer with m_last: oidx←0, go to LOAD.
- arg0/arg1 hold their values from the last LOAD until overwritten by the next LOAD. This guarantees the kernel samples stable operands for the whole latency window.
- s_valid outside LOAD is ignored; no data is lost because s_ready=0.
- m_ready low in DRAIN stalls: m_data, m_last and oidx hold.
- kern_out is sampled only at the WAIT→DRAIN edge; all other values are ignored.
- No arithmetic in this block; elements pass through bit-exact. Kernel mod-2^DW wrap is not corrected.
- Counter widths: $clog2(2*N*N) for idx, $clog2(N*N) for oidx, $clog2(PIPE_LAT+1) for wcnt.
- Reset mid-operation, in any state: partial loads and the pending result are discarded, and all reset values apply immediately.
- Back-to-back jobs: LOAD may accept a transfer in the cycle right after the final DRAIN transfer.

Optional Feature:
- Macro GEMM_HOST_JOBCNT_EN.
- When defined: adds output port job_cnt (16 bits).
  - Reset value 0.
  - Increments on each output transfer with m_last=1.
  - Wraps 0xFFFF→0x0000.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Basic GEMM with N=2, DW=32, m_ready=1. Stream 1,2,3,4,5,6,7,8 with no gaps.
  - arg0=0x00000004_00000003_00000002_00000001 and arg1=0x00000008_00000007_00000006_00000005.
  - With the real kernel: m_data 19,22,43,50; m_last only on 50.
  - m_valid rises exactly 7 edges after the 8th input transfer.
- Output backpressure: same job; hold m_ready=0 for 5 cycles, then toggle 1/0.
  - Each element appears exactly once, in order; m_data is stable while stalled.
  - busy stays 1 until the 50 transfer.
- Input gaps: same operands with s_valid low 3 cycles between each element.
  - Identical results; s_ready=0 throughout WAIT and DRAIN even with s_valid=1.
- Wrap passthrough: A=[[0xFFFFFFFF,0],[0,0]], B=[[2,0],[0,0]].
  - Output 0xFFFFFFFE,0,0,0.
- Reset mid-load: assert rst after 5 transfers, release, then run the basic job.
  - arg0/arg1=0 immediately on reset assertion; the subsequent job yields 19,22,43,50.
- Job counter (GEMM_HOST_JOBCNT_EN defined): 3 back-to-back basic jobs.
  - job_cnt=3 after the third m_last transfer.
  - Forced preload 0xFFFF plus one job gives 0.
